// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 host-to-device transmitter:
//   FSM state encoding, frame/command constants and small helper functions.
//   No ports (package).
package ps2_pkg;

  typedef enum logic [2:0] {
    PS2_IDLE       = 3'd0,
    PS2_INHIBIT    = 3'd1,
    PS2_WAIT_FIRST = 3'd2,
    PS2_SHIFT      = 3'd3,
    PS2_ACK        = 3'd4,
    PS2_WAIT_IDLE  = 3'd5,
    PS2_FAIL       = 3'd6
  } ps2_tx_state_t;

  localparam int DATA_BITS   = 8;
  localparam int FRAME_EDGES = 11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  // Whole-MHz clocks only; the division happens first so the product
  // stays inside 32 bits for realistic timeouts.
  function automatic logic [31:0] us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return 32'((clk_hz / 32'd1_000_000) * us);
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if
//   Command handshake between a host controller and ps2_host_tx.
//   tx_data/tx_valid   : command byte and request (master -> slave)
//   tx_ready/busy      : idle / transfer-in-progress status
//   done               : one-cycle end-of-transfer pulse
//   ack_err/timeout_err: failure cause, valid with done, held until next accept
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout_err
  );
endinterface

// File: rtl/ps2_sync.sv
// ps2_sync
//   Two-flop synchronizer for a raw PS/2 pin plus a falling-edge pulse.
//   clk, clrn : system clock, async active-low reset
//   din_i     : raw pin level
//   sync_o    : synchronized level
//   fall_o    : one-cycle pulse when the synchronized level goes 1 -> 0
module ps2_sync (
  input  logic clk,
  input  logic clrn,
  input  logic din_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Reset to 1 because an idle PS/2 line is pulled high; this avoids a
  // spurious falling edge right after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock
//   frame driven on device falling edges, acknowledge check, and result
//   reporting. Pins are open-drain: an *_oe of 1 pulls the line low.
//   clk, clrn    : system clock, async active-low reset
//   bus          : command handshake (ps2_host_tx_if.slave)
//   ps2_clk_in   : raw PS/2 clock pin level
//   ps2_data_in  : raw PS/2 data pin level
//   ps2_clk_oe   : 1 pulls the clock pin low
//   ps2_data_oe  : 1 pulls the data pin low
//   Build option: PS2_TX_RETRY_EN - retry the same byte once after a NACK or
//   timeout; only the final attempt reports done and error flags.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
  input  logic         clk,
  input  logic         clrn,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

`ifdef PS2_TX_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE       = PS2_IDLE;
  localparam logic [2:0] ST_INHIBIT    = PS2_INHIBIT;
  localparam logic [2:0] ST_WAIT_FIRST = PS2_WAIT_FIRST;
  localparam logic [2:0] ST_SHIFT      = PS2_SHIFT;
  localparam logic [2:0] ST_ACK        = PS2_ACK;
  localparam logic [2:0] ST_WAIT_IDLE  = PS2_WAIT_IDLE;
  localparam logic [2:0] ST_FAIL       = PS2_FAIL;

  localparam logic [31:0] InhibitCyc = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam logic [31:0] StartCyc   = us_to_cycles(CLK_HZ, START_TIMEOUT_US);
  localparam logic [31:0] FrameCyc   = us_to_cycles(CLK_HZ, FRAME_TIMEOUT_US);
  // Edges 1..9 put data bits then parity on the line; edge 10 is the stop bit.
  localparam logic [3:0]  LastDrvEdge = 4'(DATA_BITS + 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [8:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  edge_cnt_q, edge_cnt_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        timeout_err_q, timeout_err_d;
  logic        fail_nack_q, fail_nack_d;
  logic        retry_q, retry_d;

  logic clk_sync, clk_fall, data_sync, data_fall_unused;
  logic [31:0] cnt_inc, frame_inc;
  logic frame_expired;

  ps2_sync u_clk_sync (
    .clk(clk), .clrn(clrn), .din_i(ps2_clk_in),
    .sync_o(clk_sync), .fall_o(clk_fall)
  );

  ps2_sync u_data_sync (
    .clk(clk), .clrn(clrn), .din_i(ps2_data_in),
    .sync_o(data_sync), .fall_o(data_fall_unused)
  );

  assign cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
  assign frame_inc     = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 32'd1;
  assign frame_expired = (frame_cnt_q >= FrameCyc - 32'd1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_cnt_d   = frame_cnt_q;
    shift_d       = shift_q;
    data_d        = data_q;
    edge_cnt_d    = edge_cnt_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    done_d        = 1'b0;
    ack_err_d     = ack_err_q;
    timeout_err_d = timeout_err_q;
    fail_nack_d   = fail_nack_q;
    retry_d       = retry_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.tx_valid) begin
          data_d        = bus.tx_data;
          shift_d       = {odd_parity(bus.tx_data), bus.tx_data};
          ack_err_d     = 1'b0;
          timeout_err_d = 1'b0;
          retry_d       = 1'b0;
          cnt_d         = '0;
          clk_oe_d      = 1'b1;
          data_oe_d     = 1'b0;
          state_d       = ST_INHIBIT;
        end
      end

      // Clock is held low for InhibitCyc cycles; data goes low on the last
      // of them so the start bit is in place when the clock is released.
      ST_INHIBIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == InhibitCyc - 32'd2) begin
          data_oe_d = 1'b1;
        end
        if (cnt_q >= InhibitCyc - 32'd1) begin
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_WAIT_FIRST;
        end
      end

      ST_WAIT_FIRST: begin
        cnt_d = cnt_inc;
        if (clk_fall) begin
          edge_cnt_d  = 4'd1;
          data_oe_d   = ~shift_q[0];
          shift_d     = {1'b0, shift_q[8:1]};
          frame_cnt_d = '0;
          state_d     = ST_SHIFT;
        end else if (cnt_q >= StartCyc - 32'd1) begin
          fail_nack_d = 1'b0;
          clk_oe_d    = 1'b0;
          data_oe_d   = 1'b0;
          state_d     = ST_FAIL;
        end
      end

      ST_SHIFT: begin
        frame_cnt_d = frame_inc;
        if (frame_expired) begin
          fail_nack_d = 1'b0;
          data_oe_d   = 1'b0;
          state_d     = ST_FAIL;
        end else if (clk_fall) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (edge_cnt_q < LastDrvEdge) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end else begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        frame_cnt_d = frame_inc;
        if (frame_expired) begin
          fail_nack_d = 1'b0;
          state_d     = ST_FAIL;
        end else if (clk_fall) begin
          if (data_sync) begin
            fail_nack_d = 1'b1;
            state_d     = ST_FAIL;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        frame_cnt_d = frame_inc;
        if (frame_expired) begin
          fail_nack_d = 1'b0;
          state_d     = ST_FAIL;
        end else if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      // Errors are only published when no retry remains, so an attempt
      // that is retried stays invisible to the host.
      ST_FAIL: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (RetryEn && !retry_q) begin
          retry_d  = 1'b1;
          shift_d  = {odd_parity(data_q), data_q};
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end else begin
          done_d        = 1'b1;
          ack_err_d     = fail_nack_q;
          timeout_err_d = ~fail_nack_q;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Output enables are registers with async reset so both lines are
  // released the moment clrn asserts, even mid-frame.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      frame_cnt_q   <= '0;
      shift_q       <= '0;
      data_q        <= '0;
      edge_cnt_q    <= '0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      fail_nack_q   <= 1'b0;
      retry_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      edge_cnt_q    <= edge_cnt_d;
      clk_oe_q      <= clk_oe_d;
      data_oe_q     <= data_oe_d;
      done_q        <= done_d;
      ack_err_q     <= ack_err_d;
      timeout_err_q <= timeout_err_d;
      fail_nack_q   <= fail_nack_d;
      retry_q       <= retry_d;
    end
  end

  assign bus.tx_ready    = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.ack_err     = ack_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign ps2_clk_oe      = clk_oe_q;
  assign ps2_data_oe     = data_oe_q;

endmodule
